// File: rtl/comparator32b_pkg.sv
// Shared constants and flag helpers for the 32-bit bit-sliced magnitude comparator.
package comparator32b_pkg;

    localparam int CMP_WIDTH   = 32;
    localparam int SLICE_WIDTH = 4;
    localparam int NUM_SLICES  = 8;

    typedef struct packed {
        logic gr;
        logic lt;
        logic eq;
    } cmp_flags_t;

    // When the sign bits differ, the negative operand is the smaller one.
    function automatic cmp_flags_t sign_resolve(input logic a_msb, input logic b_msb);
        cmp_flags_t f;
        f.gr = b_msb;
        f.lt = a_msb;
        f.eq = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/comparator32b_cmp4b.sv
// cmp4b: 4-bit unsigned magnitude comparator slice, one-hot gr/lt/eq outputs.
module cmp4b
    import comparator32b_pkg::*;
(
    input  logic [SLICE_WIDTH-1:0] a,
    input  logic [SLICE_WIDTH-1:0] b,
    output logic                   gr,
    output logic                   lt,
    output logic                   eq
);

    // Combinational slice compare.
    always_comb begin
        gr = 1'b0;
        lt = 1'b0;
        eq = 1'b0;
        if (a > b) begin
            gr = 1'b1;
        end else if (a < b) begin
            lt = 1'b1;
        end else begin
            eq = 1'b1;
        end
    end

endmodule

// File: rtl/comparator32b.sv
// comparator32b: registered 32-bit comparator built from eight cmp4b slices.
// Define COMPARATOR32B_SIGNED_EN for a two's-complement compare; the default build is unsigned.
module comparator32b
    import comparator32b_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a0,  input logic a1,  input logic a2,  input logic a3,
    input  logic a4,  input logic a5,  input logic a6,  input logic a7,
    input  logic a8,  input logic a9,  input logic a10, input logic a11,
    input  logic a12, input logic a13, input logic a14, input logic a15,
    input  logic a16, input logic a17, input logic a18, input logic a19,
    input  logic a20, input logic a21, input logic a22, input logic a23,
    input  logic a24, input logic a25, input logic a26, input logic a27,
    input  logic a28, input logic a29, input logic a30, input logic a31,
    input  logic b0,  input logic b1,  input logic b2,  input logic b3,
    input  logic b4,  input logic b5,  input logic b6,  input logic b7,
    input  logic b8,  input logic b9,  input logic b10, input logic b11,
    input  logic b12, input logic b13, input logic b14, input logic b15,
    input  logic b16, input logic b17, input logic b18, input logic b19,
    input  logic b20, input logic b21, input logic b22, input logic b23,
    input  logic b24, input logic b25, input logic b26, input logic b27,
    input  logic b28, input logic b29, input logic b30, input logic b31,
    output logic gr,
    output logic lt,
    output logic eq
);

    logic [CMP_WIDTH-1:0]  a_s;
    logic [CMP_WIDTH-1:0]  b_s;
    logic [NUM_SLICES-1:0] slice_gr_s;
    logic [NUM_SLICES-1:0] slice_lt_s;
    logic [NUM_SLICES-1:0] slice_eq_s;
    logic                  decided_s;
    cmp_flags_t            cascade_s;
    cmp_flags_t            flags_d;
    logic                  gr_q, lt_q, eq_q;

    assign a_s = {a31, a30, a29, a28, a27, a26, a25, a24,
                  a23, a22, a21, a20, a19, a18, a17, a16,
                  a15, a14, a13, a12, a11, a10, a9,  a8,
                  a7,  a6,  a5,  a4,  a3,  a2,  a1,  a0};
    assign b_s = {b31, b30, b29, b28, b27, b26, b25, b24,
                  b23, b22, b21, b20, b19, b18, b17, b16,
                  b15, b14, b13, b12, b11, b10, b9,  b8,
                  b7,  b6,  b5,  b4,  b3,  b2,  b1,  b0};

    for (genvar g = 0; g < NUM_SLICES; g++) begin : g_slice
        cmp4b u_cmp4b (
            .a  (a_s[g*SLICE_WIDTH +: SLICE_WIDTH]),
            .b  (b_s[g*SLICE_WIDTH +: SLICE_WIDTH]),
            .gr (slice_gr_s[g]),
            .lt (slice_lt_s[g]),
            .eq (slice_eq_s[g])
        );
    end

    // MSB-priority cascade: the highest slice that is not equal decides.
    always_comb begin
        cascade_s = '{gr: 1'b0, lt: 1'b0, eq: 1'b1};
        decided_s = 1'b0;
        for (int i = NUM_SLICES - 1; i >= 0; i--) begin
            if (!decided_s && !slice_eq_s[i]) begin
                cascade_s = '{gr: slice_gr_s[i], lt: slice_lt_s[i], eq: 1'b0};
                decided_s = 1'b1;
            end else begin
                decided_s = decided_s;
            end
        end
    end

    // Signed fix-up: only the sign-bit decision flips; eq is untouched.
    always_comb begin
        flags_d = cascade_s;
`ifdef COMPARATOR32B_SIGNED_EN
        if (a_s[CMP_WIDTH-1] != b_s[CMP_WIDTH-1]) begin
            flags_d = sign_resolve(a_s[CMP_WIDTH-1], b_s[CMP_WIDTH-1]);
        end else begin
            flags_d = cascade_s;
        end
`endif
    end

    // Output register stage with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gr_q <= 1'b0;
            lt_q <= 1'b0;
            eq_q <= 1'b0;
        end else begin
            gr_q <= flags_d.gr;
            lt_q <= flags_d.lt;
            eq_q <= flags_d.eq;
        end
    end

    assign gr = gr_q;
    assign lt = lt_q;
    assign eq = eq_q;

endmodule

// File: tb/tb_comparator32b.sv
// Self-checking bench for comparator32b; expectations are queued at drive time and popped one edge later.
// Define COMPARATOR32B_SIGNED_EN here as for the RTL to check the signed build.
module tb_comparator32b;

    logic        clk;
    logic        rst;
    logic [31:0] a_v;
    logic [31:0] b_v;
    logic        gr, lt, eq;

    int total;
    int bad;
    logic [2:0] exp_q[$];

    comparator32b dut (
        .clk(clk), .rst(rst),
        .a0 (a_v[0]),  .a1 (a_v[1]),  .a2 (a_v[2]),  .a3 (a_v[3]),
        .a4 (a_v[4]),  .a5 (a_v[5]),  .a6 (a_v[6]),  .a7 (a_v[7]),
        .a8 (a_v[8]),  .a9 (a_v[9]),  .a10(a_v[10]), .a11(a_v[11]),
        .a12(a_v[12]), .a13(a_v[13]), .a14(a_v[14]), .a15(a_v[15]),
        .a16(a_v[16]), .a17(a_v[17]), .a18(a_v[18]), .a19(a_v[19]),
        .a20(a_v[20]), .a21(a_v[21]), .a22(a_v[22]), .a23(a_v[23]),
        .a24(a_v[24]), .a25(a_v[25]), .a26(a_v[26]), .a27(a_v[27]),
        .a28(a_v[28]), .a29(a_v[29]), .a30(a_v[30]), .a31(a_v[31]),
        .b0 (b_v[0]),  .b1 (b_v[1]),  .b2 (b_v[2]),  .b3 (b_v[3]),
        .b4 (b_v[4]),  .b5 (b_v[5]),  .b6 (b_v[6]),  .b7 (b_v[7]),
        .b8 (b_v[8]),  .b9 (b_v[9]),  .b10(b_v[10]), .b11(b_v[11]),
        .b12(b_v[12]), .b13(b_v[13]), .b14(b_v[14]), .b15(b_v[15]),
        .b16(b_v[16]), .b17(b_v[17]), .b18(b_v[18]), .b19(b_v[19]),
        .b20(b_v[20]), .b21(b_v[21]), .b22(b_v[22]), .b23(b_v[23]),
        .b24(b_v[24]), .b25(b_v[25]), .b26(b_v[26]), .b27(b_v[27]),
        .b28(b_v[28]), .b29(b_v[29]), .b30(b_v[30]), .b31(b_v[31]),
        .gr(gr), .lt(lt), .eq(eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built on the language's own relational operators.
    function automatic logic [2:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
        logic g, l;
`ifdef COMPARATOR32B_SIGNED_EN
        g = ($signed(a) > $signed(b));
        l = ($signed(a) < $signed(b));
`else
        g = (a > b);
        l = (a < b);
`endif
        return {g, l, (a == b)};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        a_v = 32'h0000_0001;
        b_v = 32'h0000_0000;
        #1;
        total++;
        if ({gr, lt, eq} !== 3'b000) begin
            bad++;
            $display("FAIL reset_state got=%b want=000", {gr, lt, eq});
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({gr, lt, eq} !== 3'b000) begin
            bad++;
            $display("FAIL reset_held got=%b want=000", {gr, lt, eq});
        end
        rst = 1'b0;
    endtask

    // Directed vectors with hand-written expected flags {gr,lt,eq}.
    task automatic test_directed();
        logic [31:0] ta[$];
        logic [31:0] tb[$];
        logic [2:0]  te[$];
        logic [2:0]  got, want;
        ta = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h6D6D_6D6D, 32'h5555_5555,
               32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFE};
        tb = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h6D6D_6D6D, 32'h5555_5555,
               32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        te = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b010, 3'b010};
`ifdef COMPARATOR32B_SIGNED_EN
        ta.push_back(32'h8000_0000); tb.push_back(32'h7FFF_FFFF); te.push_back(3'b010);
        ta.push_back(32'hAAAA_AAAA); tb.push_back(32'h5555_5555); te.push_back(3'b010);
        ta.push_back(32'hFFFF_FFFF); tb.push_back(32'hFFFF_FFFE); te.push_back(3'b100);
        ta.push_back(32'hFFFF_FFFF); tb.push_back(32'h0000_0000); te.push_back(3'b010);
`else
        ta.push_back(32'h8000_0000); tb.push_back(32'h7FFF_FFFF); te.push_back(3'b100);
        ta.push_back(32'h7FFF_FFFF); tb.push_back(32'h8000_0000); te.push_back(3'b010);
        ta.push_back(32'hAAAA_AAAA); tb.push_back(32'h5555_5555); te.push_back(3'b100);
        ta.push_back(32'h3333_3333); tb.push_back(32'hCCCC_CCCC); te.push_back(3'b010);
        ta.push_back(32'hCCCC_CCCC); tb.push_back(32'hCCCC_CCCB); te.push_back(3'b100);
`endif
        // MSB priority: higher bit decides despite opposite lower bits.
        ta.push_back(32'h1000_0000); tb.push_back(32'h0FFF_FFFF); te.push_back(3'b100);
        ta.push_back(32'h1234_5670); tb.push_back(32'h1234_5671); te.push_back(3'b010);
        for (int i = 0; i < ta.size(); i++) begin
            a_v = ta[i];
            b_v = tb[i];
            exp_q.push_back(te[i]);
            @(posedge clk);
            #1;
            want = exp_q.pop_front();
            got = {gr, lt, eq};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL directed[%0d] a=%h b=%h got=%b want=%b", i, ta[i], tb[i], got, want);
            end
        end
    endtask

    task automatic test_async_reset();
        a_v = 32'h0000_0001;
        b_v = 32'h0000_0000;
        @(posedge clk);
        #1;
        total++;
        if ({gr, lt, eq} !== 3'b100) begin
            bad++;
            $display("FAIL async_pre got=%b want=100", {gr, lt, eq});
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({gr, lt, eq} !== 3'b000) begin
            bad++;
            $display("FAIL async_clear got=%b want=000", {gr, lt, eq});
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if ({gr, lt, eq} !== 3'b000) begin
            bad++;
            $display("FAIL async_hold_until_edge got=%b want=000", {gr, lt, eq});
        end
        @(posedge clk);
        #1;
        total++;
        if ({gr, lt, eq} !== 3'b100) begin
            bad++;
            $display("FAIL async_release got=%b want=100", {gr, lt, eq});
        end
    endtask

    // New random pair every cycle; one-hot checked on each output.
    task automatic test_back_to_back_random();
        logic [2:0]  got, want;
        logic [31:0] ra, rb;
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            case (i % 4)
                0: rb = ra;
                1: rb = ra ^ (32'h0000_0001 << $urandom_range(31, 0));
                default: rb = rb;
            endcase
            a_v = ra;
            b_v = rb;
            exp_q.push_back(ref_flags(ra, rb));
            @(posedge clk);
            #1;
            want = exp_q.pop_front();
            got = {gr, lt, eq};
            total++;
            if (got !== want) begin
                bad++;
                if (bad < 20) $display("FAIL random[%0d] a=%h b=%h got=%b want=%b", i, ra, rb, got, want);
            end
            total++;
            if ($countones(got) != 1) begin
                bad++;
                if (bad < 20) $display("FAIL onehot[%0d] got=%b want=one_hot", i, got);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        a_v = 32'h0000_0000;
        b_v = 32'h0000_0000;
        test_reset();
        test_directed();
        test_async_reset();
        test_back_to_back_random();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/comparator32b.md
COMPARATOR32B -- requirements
Module: comparator32b

Interface
Parameters: none; width is fixed at 32 bits.
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 a0..a31  input  1 each  operand A, bit-per-port; a0 is the LSB and a31 is the MSB.
REQ-004 b0..b31  input  1 each  operand B, bit-per-port; b0 is the LSB and b31 is the MSB.
REQ-005 gr  output  1  registered flag, high when A > B.
REQ-006 lt  output  1  registered flag, high when A < B.
REQ-007 eq  output  1  registered flag, high when A == B.

Function
REQ-008 The block SHALL form A = {a31..a0} and B = {b31..b0} as 32-bit vectors.
REQ-009 Default comparison SHALL be unsigned magnitude; e.g. 0x80000000 > 0x7FFFFFFF.
REQ-010 Outputs SHALL be computed combinationally and captured in flops on each rising clk edge.
REQ-011 Latency SHALL be exactly 1 clock from input change to flag update; there is no handshake, and a new comparison is accepted every cycle.
REQ-012 Out of reset, exactly one of gr/lt/eq SHALL be high on every cycle (one-hot invariant).
REQ-013 The comparison SHALL be decided by the most significant differing bit; lower bits SHALL be ignored once a higher bit differs.
REQ-014 Boundary cases SHALL be handled exactly: all-zeros vs all-zeros gives eq; all-ones vs all-ones gives eq; 0xFFFFFFFE vs 0xFFFFFFFF gives lt; a difference only in bit 0 is resolved correctly.
REQ-015 X/Z on any input SHALL NOT be masked; flag values in that case are unspecified.
REQ-016 The block SHALL contain no state other than the three output flops.

Reset
REQ-017 While rst is high, gr, lt and eq SHALL all be 0, asynchronously and immediately.
REQ-018 After rst deasserts, the first rising clk edge SHALL load valid flags.
REQ-019 A rst assertion mid-stream SHALL clear all flags without waiting for a clk edge.

Configuration
REQ-020 Macro COMPARATOR32B_SIGNED_EN: when defined, A and B SHALL be compared as two's-complement signed values (0x80000000 < 0x7FFFFFFF; 0xFFFFFFFF < 0x00000000). Only the bit-31 resolution is inverted when the sign bits differ.
REQ-021 When COMPARATOR32B_SIGNED_EN is undefined, the comparison SHALL be unsigned as in REQ-009.
REQ-022 The eq result SHALL be identical in both builds.

Structure
REQ-023 A shared package comparator32b_pkg SHALL hold the constants CMP_WIDTH=32, SLICE_WIDTH=4 and NUM_SLICES=8.
REQ-024 One sub-module, cmp4b, SHALL be used: a 4-bit magnitude comparator with outputs gr/lt/eq.
REQ-025 The top level SHALL instantiate 8 cmp4b slices and combine them with an MSB-priority cascade: a slice result wins if all higher slices report eq.
REQ-026 The top level SHALL contain the signed fix-up (under the macro) and the output register stage.

Verification
REQ-027 A=0x00000000, B=0x00000000 -> after 1 clk: gr=0, lt=0, eq=1. Repeat with A=B=0xFFFFFFFF, A=B=0x6D6D6D6D and A=B=0x55555555 -> eq=1 each time.
REQ-028 A=0x00000001, B=0x00000000 -> gr=1, lt=0, eq=0. A=0x00000000, B=0x00000001 -> lt=1. A=0xFFFFFFFE, B=0xFFFFFFFF -> lt=1.
REQ-029 Unsigned build: A=0x80000000, B=0x7FFFFFFF -> gr=1; A=0x7FFFFFFF, B=0x80000000 -> lt=1; A=0xAAAAAAAA, B=0x55555555 -> gr=1; A=0x33333333, B=0xCCCCCCCC -> lt=1; A=0xCCCCCCCC, B=0xCCCCCCCB -> gr=1.
REQ-030 Signed build (COMPARATOR32B_SIGNED_EN defined): A=0x80000000, B=0x7FFFFFFF -> lt=1; A=0xAAAAAAAA, B=0x55555555 -> lt=1; A=0xFFFFFFFF, B=0xFFFFFFFE -> gr=1.
REQ-031 Reset: apply A=1, B=0 and let gr=1 register, then assert rst between clk edges -> gr/lt/eq=0 with no edge required. Release rst -> gr=1 on the next edge.
REQ-032 Random run: 10,000 random A/B pairs, each checked one cycle later against a reference model, with the one-hot invariant asserted every cycle.
